// File: rtl/aes_pnm_seq_ctrl_if.sv
// Command/status and array-strobe bundle between host, round-key supplier and
// the AES near-memory round sequencer.
interface aes_pnm_seq_ctrl_if #(
   parameter int ADDR_W = 6,
   parameter int BLK_W  = 4
);
   logic              start;
   logic              abort;
   logic              enc_dec;
   logic [1:0]        key_mode;
   logic [ADDR_W-1:0] base_addr;
   logic [BLK_W-1:0]  num_blocks;
   logic              rk_ack;
   logic              busy;
   logic              done;
   logic              err;
   logic              sra_en;
   logic              pe_en;
   logic              load_psum;
   logic              subbytes_sel;
   logic              mem_wr_en;
   logic [1:0]        op_sel;
   logic              inv_sel;
   logic [ADDR_W-1:0] row_addr;
   logic [ADDR_W-1:0] mem_wr_row;
   logic [3:0]        round;
   logic [BLK_W-1:0]  blk_idx;
   logic              rk_req;

   modport master (
      output start, abort, enc_dec, key_mode, base_addr, num_blocks, rk_ack,
      input  busy, done, err, sra_en, pe_en, load_psum, subbytes_sel, mem_wr_en,
             op_sel, inv_sel, row_addr, mem_wr_row, round, blk_idx, rk_req
   );

   modport slave (
      input  start, abort, enc_dec, key_mode, base_addr, num_blocks, rk_ack,
      output busy, done, err, sra_en, pe_en, load_psum, subbytes_sel, mem_wr_en,
             op_sel, inv_sel, row_addr, mem_wr_row, round, blk_idx, rk_req
   );
endinterface

// File: rtl/aes_pnm_seq_ctrl.sv
// Multi-block AES-128/192/256 round sequencer for the FeRAM near-memory array.
// Optional round-key handshake in KEY is enabled by defining AES_PNM_RKREQ_EN.
module aes_pnm_seq_ctrl #(
   parameter int ROWS   = 4,
   parameter int ADDR_W = 6,
   parameter int BLK_W  = 4
) (
   input  logic                clk,
   input  logic                rst_n,
   aes_pnm_seq_ctrl_if.slave   bus
);
   localparam int RC_W = (ROWS > 1) ? $clog2(ROWS) : 1;

   typedef enum logic [2:0] {
      IDLE, LOAD, SUB, MIX, KEY, STORE, NEXT, DONE
   } state_t;

   state_t            state, nxt;
   logic [RC_W-1:0]   row_cnt;
   logic [3:0]        round_q;
   logic [BLK_W-1:0]  blk_q;
   logic              err_q;
   logic              enc_q;
   logic [3:0]        nr_q;
   logic [ADDR_W-1:0] base_q;
   logic [BLK_W-1:0]  nblk_q;

   logic              row_last, first_round, last_round, last_blk, illegal, key_go;
   logic [ADDR_W-1:0] addr;

   function automatic logic [3:0] nr_of(input logic [1:0] km);
      case (km)
         2'b00:   nr_of = 4'd10;
         2'b01:   nr_of = 4'd12;
         default: nr_of = 4'd14;
      endcase
   endfunction

`ifdef AES_PNM_RKREQ_EN
   assign key_go = bus.rk_ack;
`else
   logic unused_rk_ack;
   assign unused_rk_ack = bus.rk_ack;
   assign key_go        = 1'b1;
`endif

   assign row_last    = (row_cnt == RC_W'(ROWS - 1));
   // first_round is the round with no SubBytes (r=0 enc, r=Nr dec); last_round ends the block
   assign first_round = enc_q ? (round_q == 4'd0) : (round_q == nr_q);
   assign last_round  = enc_q ? (round_q == nr_q) : (round_q == 4'd0);
   assign last_blk    = (blk_q == nblk_q - BLK_W'(1));
   assign illegal     = (bus.key_mode == 2'b11) || (bus.num_blocks == '0);
   assign addr        = base_q + ADDR_W'(32'(blk_q) * ROWS) + ADDR_W'(row_cnt);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= nxt;
   end

   always_comb begin
      nxt = state;
      case (state)
         IDLE:    if (bus.start) nxt = illegal ? DONE : LOAD;
         LOAD:    if (row_last) nxt = first_round ? KEY : SUB;
         SUB:     nxt = (enc_q && !last_round) ? MIX : KEY;
         MIX:     nxt = enc_q ? KEY : STORE;
         KEY:     if (key_go) nxt = (enc_q || first_round || last_round) ? STORE : MIX;
         STORE:   if (row_last) nxt = NEXT;
         NEXT:    nxt = (last_round && last_blk) ? DONE : LOAD;
         DONE:    nxt = IDLE;
         default: nxt = IDLE;
      endcase
      if (bus.abort) nxt = IDLE;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         row_cnt <= '0;
         round_q <= '0;
         blk_q   <= '0;
         err_q   <= 1'b0;
      end else if (nxt == IDLE) begin
         row_cnt <= '0;
         round_q <= '0;
         blk_q   <= '0;
         err_q   <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               row_cnt <= '0;
               blk_q   <= '0;
               err_q   <= illegal;
               if (!illegal) round_q <= bus.enc_dec ? 4'd0 : nr_of(bus.key_mode);
            end
            LOAD, STORE: row_cnt <= row_last ? '0 : row_cnt + RC_W'(1);
            NEXT: begin
               if (!last_round)
                  round_q <= enc_q ? round_q + 4'd1 : round_q - 4'd1;
               else if (!last_blk) begin
                  blk_q   <= blk_q + BLK_W'(1);
                  round_q <= enc_q ? 4'd0 : nr_q;
               end
            end
            default: ;
         endcase
      end
   end

   // Command fields are only observed while busy, so they need no reset
   always_ff @(posedge clk) begin
      if (state == IDLE && bus.start) begin
         enc_q  <= bus.enc_dec;
         nr_q   <= nr_of(bus.key_mode);
         base_q <= bus.base_addr;
         nblk_q <= bus.num_blocks;
      end
   end

   always_comb begin
      bus.busy         = (state != IDLE);
      bus.done         = 1'b0;
      bus.err          = 1'b0;
      bus.sra_en       = 1'b0;
      bus.pe_en        = 1'b0;
      bus.load_psum    = 1'b0;
      bus.subbytes_sel = 1'b0;
      bus.mem_wr_en    = 1'b0;
      bus.op_sel       = 2'b00;
      bus.inv_sel      = (state != IDLE) && !enc_q;
      bus.row_addr     = '0;
      bus.mem_wr_row   = '0;
      bus.round        = round_q;
      bus.blk_idx      = blk_q;
      bus.rk_req       = 1'b0;
      case (state)
         LOAD: begin
            bus.sra_en    = 1'b1;
            bus.pe_en     = 1'b1;
            bus.load_psum = 1'b1;
            bus.row_addr  = addr;
         end
         SUB: begin
            bus.pe_en        = 1'b1;
            bus.load_psum    = 1'b1;
            bus.subbytes_sel = 1'b1;
         end
         MIX: begin
            bus.pe_en  = 1'b1;
            bus.op_sel = 2'b10;
         end
         KEY: begin
            bus.pe_en  = key_go;
            bus.op_sel = key_go ? 2'b01 : 2'b00;
`ifdef AES_PNM_RKREQ_EN
            bus.rk_req = 1'b1;
`endif
         end
         STORE: begin
            bus.mem_wr_en  = 1'b1;
            bus.mem_wr_row = addr;
         end
         DONE: begin
            bus.done = 1'b1;
            bus.err  = err_q;
         end
         default: ;
      endcase
   end
endmodule

// File: tb/tb_aes_pnm_seq_ctrl.sv
// Randomized self-checking bench for aes_pnm_seq_ctrl against a round-table
// reference model of the expected per-cycle output trace.
module tb_aes_pnm_seq_ctrl;
   localparam int ROWS   = 4;
   localparam int ADDR_W = 6;
   localparam int BLK_W  = 4;
`ifdef AES_PNM_RKREQ_EN
   localparam int STALL = 3;
   localparam bit RKREQ = 1'b1;
`else
   localparam int STALL = 0;
   localparam bit RKREQ = 1'b0;
`endif
   localparam int PL = 0, PS = 1, PM = 2, PK = 3, PW = 4;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   aes_pnm_seq_ctrl_if #(.ADDR_W(ADDR_W), .BLK_W(BLK_W)) bus ();
   aes_pnm_seq_ctrl #(.ROWS(ROWS), .ADDR_W(ADDR_W), .BLK_W(BLK_W)) dut (
      .clk(clk), .rst_n(rst_n), .bus(bus)
   );

   int checks   = 0;
   int failures = 0;
   logic [31:0] exp_q[$];
   bit          ack_q[$];

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got=%h expected=%h", tag, got, exp);
      end
   endtask

   // {busy,done,err,sra,pe,load_psum,subbytes,wr,op[1:0],inv,rk_req,round[3:0],blk[3:0],row_addr[5:0],wr_row[5:0]}
   function automatic logic [31:0] pk(input bit busy, done, err, sra, pe, lp, sb, wr,
                                      input bit [1:0] op, input bit inv, rkr,
                                      input int rnd, blk, ra, wa);
      return {busy, done, err, sra, pe, lp, sb, wr, op, inv, rkr,
              4'(rnd), 4'(blk), 6'(ra), 6'(wa)};
   endfunction

   function automatic logic [31:0] obs();
      return pk(bus.busy, bus.done, bus.err, bus.sra_en, bus.pe_en, bus.load_psum,
                bus.subbytes_sel, bus.mem_wr_en, bus.op_sel, bus.inv_sel, bus.rk_req,
                int'(bus.round), int'(bus.blk_idx), int'(bus.row_addr), int'(bus.mem_wr_row));
   endfunction

   function automatic void push(input logic [31:0] v, input bit ack);
      exp_q.push_back(v);
      ack_q.push_back(ack);
   endfunction

   function automatic void push_phase(input int ph, input bit inv, input int r, b, base);
      int a;
      case (ph)
         PL, PW:
            for (int row = 0; row < ROWS; row++) begin
               a = (base + b * ROWS + row) % (1 << ADDR_W);
               if (ph == PL) push(pk(1,0,0,1,1,1,0,0,2'b00,inv,0,r,b,a,0), 1'($urandom));
               else          push(pk(1,0,0,0,0,0,0,1,2'b00,inv,0,r,b,0,a), 1'($urandom));
            end
         PS: push(pk(1,0,0,0,1,1,1,0,2'b00,inv,0,r,b,0,0), 1'($urandom));
         PM: push(pk(1,0,0,0,1,0,0,0,2'b10,inv,0,r,b,0,0), 1'($urandom));
         default: begin
            for (int s = 0; s < STALL; s++) push(pk(1,0,0,0,0,0,0,0,2'b00,inv,1,r,b,0,0), 1'b0);
            push(pk(1,0,0,0,1,0,0,0,2'b01,inv,RKREQ,r,b,0,0), RKREQ ? 1'b1 : 1'($urandom));
         end
      endcase
   endfunction

   // Expected output of every cycle following the start-sampling edge, ending with one IDLE cycle
   function automatic void build(input bit enc, input int km, base, nb);
      int nr, r;
      int seq[$];
      exp_q.delete();
      ack_q.delete();
      nr = 10 + 2 * km;
      if (km == 3 || nb == 0) begin
         push(pk(1,1,1,0,0,0,0,0,2'b00,!enc,0,0,0,0,0), 1'($urandom));
      end else begin
         for (int b = 0; b < nb; b++) begin
            for (int s = 0; s <= nr; s++) begin
               r = enc ? s : nr - s;
               if (s == 0)       seq = '{PL, PK, PW};
               else if (s == nr) seq = '{PL, PS, PK, PW};
               else if (enc)     seq = '{PL, PS, PM, PK, PW};
               else              seq = '{PL, PS, PK, PM, PW};
               foreach (seq[k]) push_phase(seq[k], !enc, r, b, base);
               push(pk(1,0,0,0,0,0,0,0,2'b00,!enc,0,r,b,0,0), 1'($urandom));
            end
         end
         push(pk(1,1,0,0,0,0,0,0,2'b00,!enc,0,enc ? nr : 0,nb - 1,0,0), 1'($urandom));
      end
      push(32'd0, 1'($urandom));
   endfunction

   task automatic run(input bit enc, input int km, base, nb, abort_round,
                      output int lat, output int mix_n, output int mix_edge_n, output int wr_lo_n);
      int abort_at = -1;
      build(enc, km, base, nb);
      if (abort_round >= 0) begin
         for (int i = 0; i < exp_q.size(); i++)
            if (exp_q[i][24] && exp_q[i][19:16] == 4'(abort_round)) begin
               abort_at = i + 1;
               break;
            end
         while (exp_q.size() > abort_at + 1) begin
            void'(exp_q.pop_back());
            void'(ack_q.pop_back());
         end
         push(32'd0, 1'b0);
      end
      lat = -1; mix_n = 0; mix_edge_n = 0; wr_lo_n = 0;
      @(negedge clk);
      bus.start      = 1'b1;
      bus.enc_dec    = enc;
      bus.key_mode   = 2'(km);
      bus.base_addr  = ADDR_W'(base);
      bus.num_blocks = BLK_W'(nb);
      @(posedge clk);
      for (int i = 0; i < exp_q.size(); i++) begin
         #1;
         bus.start      = (i < exp_q.size() - 2) && ($urandom_range(3) == 0);
         bus.enc_dec    = 1'($urandom);
         bus.key_mode   = 2'($urandom);
         bus.base_addr  = ADDR_W'($urandom);
         bus.num_blocks = BLK_W'($urandom);
         bus.rk_ack     = ack_q[i];
         bus.abort      = (i == abort_at);
         @(negedge clk);
         check($sformatf("trace[%0d]", i), obs(), exp_q[i]);
         if (bus.done && lat < 0) lat = i;
         if (bus.op_sel == 2'b10) begin
            mix_n++;
            if (bus.round == 4'd0 || bus.round == 4'd10) mix_edge_n++;
         end
         if (bus.mem_wr_en && bus.mem_wr_row < 6'd4) wr_lo_n++;
         @(posedge clk);
      end
      #1;
      bus.start = 1'b0;
      bus.abort = 1'b0;
   endtask

   function automatic int exp_lat(input int km, nb);
      int nr = 10 + 2 * km;
      return nb * ((nr + 1) * (2 * ROWS + 1) + 3 * nr + STALL * (nr + 1));
   endfunction

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int lat, mix_n, mix_edge_n, wr_lo_n;
      bit enc;
      int km, base, nb;
      bus.start = 0; bus.abort = 0; bus.enc_dec = 0; bus.key_mode = 0;
      bus.base_addr = 0; bus.num_blocks = 0; bus.rk_ack = 0;
      #12;
      check("reset_outputs", obs(), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      check("idle_after_reset", obs(), 32'd0);

      run(1'b1, 0, 0, 1, -1, lat, mix_n, mix_edge_n, wr_lo_n);
      check("enc128_latency", 32'(lat), 32'(exp_lat(0, 1)));
      check("enc128_mix_count", 32'(mix_n), 32'd9);
      check("enc128_mix_edge_rounds", 32'(mix_edge_n), 32'd0);
      check("enc128_writes_rows_0_3", 32'(wr_lo_n), 32'd44);

      run(1'b0, 2, 8, 2, -1, lat, mix_n, mix_edge_n, wr_lo_n);
      check("dec256_latency", 32'(lat), 32'(exp_lat(2, 2)));

      run(1'b1, 3, 5, 1, -1, lat, mix_n, mix_edge_n, wr_lo_n);
      check("illegal_keymode_latency", 32'(lat), 32'd0);
      run(1'b0, 0, 5, 0, -1, lat, mix_n, mix_edge_n, wr_lo_n);
      check("illegal_zero_blocks_latency", 32'(lat), 32'd0);

      run(1'b1, 1, 62, 1, -1, lat, mix_n, mix_edge_n, wr_lo_n);
      check("wrap_latency", 32'(lat), 32'(exp_lat(1, 1)));

      run(1'b1, 0, 20, 1, 5, lat, mix_n, mix_edge_n, wr_lo_n);
      check("abort_no_done", 32'(lat), 32'hFFFF_FFFF);
      run(1'b0, 0, 40, 1, -1, lat, mix_n, mix_edge_n, wr_lo_n);
      check("restart_latency", 32'(lat), 32'(exp_lat(0, 1)));

      for (int t = 0; t < 6; t++) begin
         enc  = 1'($urandom);
         km   = $urandom_range(2);
         base = $urandom_range(63);
         nb   = $urandom_range(3, 1);
         run(enc, km, base, nb, -1, lat, mix_n, mix_edge_n, wr_lo_n);
         check($sformatf("rand%0d_latency", t), 32'(lat), 32'(exp_lat(km, nb)));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/aes_pnm_seq_ctrl.md
# aes_pnm_seq_ctrl

Parametrised multi-block AES round sequencer for the FeRAM near-memory systolic array. It drives the array's row-load (SRA), PE operation and in-place row write-back for AES-128/192/256 encryption and decryption. It processes a run of consecutive 4-row state blocks per start and supports abort and error reporting. It sits between the host command interface and the FeRAM array / PE grid, and optionally handshakes with an external round-key supplier.

## Interface
Parameters:
- ROWS, 4: array rows per AES state block (load/store beats per round).
- ADDR_W, 6: FeRAM row-address width.
- BLK_W, 4: block-count width; up to 2^BLK_W-1 blocks per command.

Ports:
- clk  in  1  clock; all state changes on posedge.
- rst_n  in  1  reset, asynchronous, active-low.
- start  in  1  command strobe; accepted only in IDLE.
- abort  in  1  synchronous abort; any state -> IDLE next cycle.
- enc_dec  in  1  1=encrypt, 0=decrypt; latched at start.
- key_mode  in  2  00=AES-128 (Nr=10), 01=AES-192 (Nr=12), 10=AES-256 (Nr=14), 11=illegal; latched.
- base_addr  in  ADDR_W  first row of block 0; latched.
- num_blocks  in  BLK_W  block count, 0 illegal; latched.
- rk_ack  in  1  round key valid (used only with AES_PNM_RKREQ_EN).
- busy  out  1  state != IDLE.
- done  out  1  one-cycle completion pulse.
- err  out  1  qualifies done: illegal command.
- sra_en, pe_en, load_psum, subbytes_sel, mem_wr_en  out  1  array strobes.
- op_sel  out  2  00 NOP, 01 XOR, 10 MIXCOL, 11 PASS.
- inv_sel  out  1  inverse datapath select (= ~latched enc_dec).
- row_addr, mem_wr_row  out  ADDR_W  read/write row address.
- round  out  4  current round index.
- blk_idx  out  BLK_W  current block.
- rk_req  out  1  round-key request.

## Operation
- States: IDLE, LOAD, SUB, MIX, KEY, STORE, NEXT, DONE.
- Start in IDLE latches the command. If key_mode==11 or num_blocks==0, go to DONE with err=1 and make no array access. Otherwise go to LOAD with blk_idx=0, row_cnt=0, round=0 (enc) or Nr (dec).
- LOAD: ROWS cycles, with sra_en=pe_en=load_psum=1.
- STORE: ROWS cycles, with mem_wr_en=1.
- Address in both LOAD and STORE: base_addr + blk_idx*ROWS + row_cnt, truncated mod 2^ADDR_W (wraps).
- Encrypt round sequences:
  - r=0: LOAD, KEY, STORE.
  - 0<r<Nr: LOAD, SUB, MIX, KEY, STORE.
  - r=Nr: LOAD, SUB, KEY, STORE.
- Decrypt round sequences:
  - r=Nr: LOAD, KEY, STORE.
  - 0<r<Nr: LOAD, SUB, KEY, MIX, STORE.
  - r=0: LOAD, SUB, KEY, STORE.
- SUB: pe_en=load_psum=subbytes_sel=1. The PE applies (Inv)SubBytes plus (Inv)ShiftRows per inv_sel.
- MIX: pe_en=1, op_sel=10.
- KEY: pe_en=1, op_sel=01.
- NEXT (1 cycle) after every STORE:
  - If the last round of the block is done: last block -> DONE; otherwise blk_idx+1 and round reloads.
  - Otherwise round steps +1 (enc) or -1 (dec), then LOAD.
- DONE: done=1 for one cycle, then IDLE.
- Undriven outputs are 0 in every state. Unused state encodings go to IDLE.
- start while busy is ignored. Abort has priority over start and all transitions. Abort produces no done pulse.

## Timing
- Reset: all outputs 0; state IDLE; round, blk_idx and row_cnt 0.
- Strobes are decoded combinationally from registered state and counters.
- The first LOAD cycle is the cycle after start is sampled.
- Cycles per block: (Nr+1)(2·ROWS+1) + 3·Nr, with no key stalls.
  - ROWS=4: 129 (AES-128), 153 (AES-192), 177 (AES-256).
  - Identical for enc and dec.
- done is asserted exactly num_blocks·cycles_per_block cycles after the start cycle.
- Illegal command: done+err in the cycle after start.

## Configuration
- AES_PNM_RKREQ_EN defined:
  - KEY drives rk_req=1.
  - pe_en and op_sel=01 are asserted only in a cycle where rk_ack=1; the state leaves KEY on that cycle.
  - KEY holds indefinitely while rk_ack=0.
  - round is stable throughout KEY; the supplier indexes the key by round.
- Undefined: rk_req is tied 0, rk_ack is ignored, and KEY is always 1 cycle.

## Test plan
- Enc AES-128, ROWS=4, base=0, num_blocks=1 -> done at cycle 129. MIX is absent in rounds 0 and 10. Write addresses 0..3 are repeated 11 times.
- Dec AES-256, num_blocks=2, base=8 -> round counts 14..0 per block. Block 1 uses addresses 12..15. done at cycle 354. inv_sel=1 throughout.
- key_mode=11 or num_blocks=0 -> done=err=1 on the next cycle, with no sra_en/mem_wr_en ever asserted.
- base_addr=62, ADDR_W=6 -> block 0 rows 62, 63, 0, 1 (wrap).
- Abort mid-STORE in round 5, then restart -> IDLE the next cycle with no done. The new command runs to completion with correct latency. start pulses during busy are ignored.
- With AES_PNM_RKREQ_EN: hold rk_ack low 3 cycles in each KEY -> latency grows by 3·(Nr+1)·num_blocks, and pe_en is asserted only when rk_ack=1.
